// File: rtl/multi_crop_filter_if.sv
// Pixel stream bundle for multi_crop_filter: input pixel handshake plus tagged output beat.
// slave is the crop stage's view; master is the source/sink side driving it.
interface multi_crop_filter_if #(
    parameter int unsigned PIXEL_BIT_WIDTH = 16,
    parameter int unsigned ID_W            = 1
);
    logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
    logic                       in_valid;
    logic                       in_ready;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
    logic [ID_W-1:0]            out_crop_id;
    logic                       out_crop_last;
    logic                       out_valid;
    logic                       out_ready;

    modport slave (
        input  pixel_in, in_valid, out_ready,
        output in_ready, pixel_out, out_crop_id, out_crop_last, out_valid
    );

    modport master (
        output pixel_in, in_valid, out_ready,
        input  in_ready, pixel_out, out_crop_id, out_crop_last, out_valid
    );
endinterface

// File: rtl/multi_crop_filter.sv
// Streaming multi-window crop: emits each input pixel once per run-time window it falls in,
// tagged with the window index, with per-frame latched window configuration.
module multi_crop_filter #(
    parameter int unsigned PIXEL_BIT_WIDTH = 16,
    parameter int unsigned IN_ROWS         = 100,
    parameter int unsigned IN_COLS         = 160,
    parameter int unsigned OUT_ROWS        = 48,
    parameter int unsigned OUT_COLS        = 48,
    parameter int unsigned NUM_CROPS       = 2,
    parameter int unsigned ROW_W           = $clog2(IN_ROWS),
    parameter int unsigned COL_W           = $clog2(IN_COLS),
    parameter int unsigned ID_W            = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CROPS-1:0]       crop_en,
    input  logic [NUM_CROPS*ROW_W-1:0] crop_y,
    input  logic [NUM_CROPS*COL_W-1:0] crop_x,
    multi_crop_filter_if.slave         px,
    output logic                       frame_done,
    output logic                       cfg_err
);
    localparam int unsigned RE_W = ROW_W + 1;
    localparam int unsigned CE_W = COL_W + 1;

    logic [ROW_W-1:0]           row_q;
    logic [COL_W-1:0]           col_q;
    logic [NUM_CROPS-1:0]       en_q;
    logic [NUM_CROPS*ROW_W-1:0] y_q;
    logic [NUM_CROPS*COL_W-1:0] x_q;
    logic [NUM_CROPS-1:0]       mask_q;
    logic [NUM_CROPS-1:0]       last_q;

    logic                       first_px;
    logic [NUM_CROPS-1:0]       en_s;
    logic [NUM_CROPS*ROW_W-1:0] y_s;
    logic [NUM_CROPS*COL_W-1:0] x_s;
    logic [NUM_CROPS-1:0]       hit;
    logic [NUM_CROPS-1:0]       hit_last;
    logic [NUM_CROPS-1:0]       misfit;
    logic                       one_left;
    logic                       in_fire;
    logic                       out_fire;
    logic                       last_px;
    logic [NUM_CROPS-1:0]       next_mask;
    logic [NUM_CROPS-1:0]       next_last_mask;
    logic [ID_W-1:0]            next_id;
    logic                       next_last;

    // Pixel (0,0) is classified against the config being latched on the same edge
    assign first_px = (row_q == '0) && (col_q == '0);
    assign en_s     = first_px ? crop_en : en_q;
    assign y_s      = first_px ? crop_y  : y_q;
    assign x_s      = first_px ? crop_x  : x_q;
    assign last_px  = (row_q == ROW_W'(IN_ROWS - 1)) && (col_q == COL_W'(IN_COLS - 1));

    for (genvar g = 0; g < NUM_CROPS; g++) begin : g_win
        logic [ROW_W-1:0] y;
        logic [COL_W-1:0] x;
        logic [RE_W-1:0]  y_end;
        logic [CE_W-1:0]  x_end;
        logic             fit;
        logic             in_rows;
        logic             in_cols;

        assign y       = y_s[g*ROW_W +: ROW_W];
        assign x       = x_s[g*COL_W +: COL_W];
        assign y_end   = RE_W'(y) + RE_W'(OUT_ROWS);
        assign x_end   = CE_W'(x) + CE_W'(OUT_COLS);
        assign fit     = (y_end <= RE_W'(IN_ROWS)) && (x_end <= CE_W'(IN_COLS));
        assign in_rows = (row_q >= y) && (RE_W'(row_q) < y_end);
        assign in_cols = (col_q >= x) && (CE_W'(col_q) < x_end);
        assign misfit[g]   = en_s[g] & ~fit;
        assign hit[g]      = en_s[g] & fit & in_rows & in_cols;
        assign hit_last[g] = (RE_W'(row_q) == y_end - RE_W'(1)) &&
                             (CE_W'(col_q) == x_end - CE_W'(1));
    end

    // Accept when the holder is empty or its final beat leaves this cycle
    assign one_left    = (mask_q != '0) && ((mask_q & (mask_q - NUM_CROPS'(1))) == '0);
    assign px.in_ready = (mask_q == '0) || (px.out_ready && one_left);
    assign in_fire     = px.in_valid && px.in_ready;
    assign out_fire    = px.out_valid && px.out_ready;

    // Remaining-window mask and the lowest-index beat to present next
    always_comb begin
        next_mask      = mask_q;
        next_last_mask = last_q;
        next_id        = '0;
        next_last      = 1'b0;
        if (in_fire) begin
            next_mask      = hit;
            next_last_mask = hit_last;
        end else if (out_fire) begin
            next_mask = mask_q & ~(NUM_CROPS'(1) << px.out_crop_id);
        end
        for (int i = NUM_CROPS - 1; i >= 0; i--) begin
            if (next_mask[i]) begin
                next_id   = ID_W'(i);
                next_last = next_last_mask[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q            <= '0;
            col_q            <= '0;
            en_q             <= '0;
            y_q              <= '0;
            x_q              <= '0;
            mask_q           <= '0;
            last_q           <= '0;
            frame_done       <= 1'b0;
            cfg_err          <= 1'b0;
            px.out_valid     <= 1'b0;
            px.pixel_out     <= '0;
            px.out_crop_id   <= '0;
            px.out_crop_last <= 1'b0;
        end else begin
            if (in_fire) begin
                if (col_q == COL_W'(IN_COLS - 1)) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_W'(IN_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            if (in_fire && first_px) begin
                en_q <= crop_en;
                y_q  <= crop_y;
                x_q  <= crop_x;
                if (misfit != '0) cfg_err <= 1'b1;
            end
            if (in_fire && (hit != '0)) px.pixel_out <= px.pixel_in;
            frame_done       <= in_fire && last_px;
            mask_q           <= next_mask;
            last_q           <= next_last_mask;
            px.out_valid     <= (next_mask != '0);
            px.out_crop_id   <= next_id;
            px.out_crop_last <= next_last;
        end
    end
endmodule
